// File: rtl/instr_cycle_sequencer_pkg.sv
// Shared definitions for the instruction cycle sequencer.
// Contents:
//   - state_t   : sequencer states. The encodings are visible on state_o.
//   - strobes_t : bundle of datapath control strobes driven during EXEC.
//   - OP_*      : 4-bit opcodes (IR[11:8]).
//   - ALU_* / ACC_* : SelALU and SelAcc codes.
package instr_cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef struct packed {
        logic       incPC;
        logic       selPC;
        logic       loadPC;
        logic       loadReg;
        logic       loadAcc;
        logic [1:0] selAcc;
        logic [3:0] selALU;
    } strobes_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVS = 4'b0100;
    localparam logic [3:0] OP_MOVD = 4'b0101;
    localparam logic [3:0] OP_JZR  = 4'b0110;
    localparam logic [3:0] OP_JZI  = 4'b0111;
    localparam logic [3:0] OP_JCR  = 4'b1000;
    localparam logic [3:0] OP_RSV9 = 4'b1001;
    localparam logic [3:0] OP_JCI  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_LDI  = 4'b1101;
    localparam logic [3:0] OP_RSVE = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // SelALU = {ALU_sel[1:0], shift ctl[1:0]}
    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1100;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SHL = 4'b0001;
    localparam logic [3:0] ALU_SHR = 4'b0011;

    localparam logic [1:0] ACC_ALU = 2'b00;
    localparam logic [1:0] ACC_RS  = 2'b01;
    localparam logic [1:0] ACC_IMM = 2'b10;

endpackage

// File: rtl/instr_cycle_sequencer_decode.sv
// Combinational instruction decoder.
// Maps the latched opcode and the latched flags to the EXEC-phase strobe
// bundle. It also flags the HALT opcode.
// Ports:
//   op      in   4  latched opcode
//   z       in   1  latched zero flag
//   c       in   1  latched carry flag
//   strobes out     EXEC strobe bundle (strobes_t)
//   isHalt  out  1  opcode is HALT
module instr_cycle_sequencer_decode
    import instr_cycle_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  logic       z,
    input  logic       c,
    output strobes_t   strobes,
    output logic       isHalt
);

    always_comb begin
        strobes = '0;
        isHalt  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHL, OP_SHR: begin
                strobes.loadAcc = 1'b1;
                strobes.incPC   = 1'b1;
                strobes.selAcc  = ACC_ALU;
                case (op)
                    OP_ADD:  strobes.selALU = ALU_ADD;
                    OP_SUB:  strobes.selALU = ALU_SUB;
                    OP_NOR:  strobes.selALU = ALU_NOR;
                    OP_SHL:  strobes.selALU = ALU_SHL;
                    default: strobes.selALU = ALU_SHR;
                endcase
            end
            OP_MOVS: begin
                strobes.selAcc  = ACC_RS;
                strobes.loadAcc = 1'b1;
                strobes.incPC   = 1'b1;
            end
            OP_MOVD: begin
                strobes.loadReg = 1'b1;
                strobes.incPC   = 1'b1;
            end
            OP_LDI: begin
                strobes.selAcc  = ACC_IMM;
                strobes.loadAcc = 1'b1;
                strobes.incPC   = 1'b1;
            end
            // Conditional jumps: a taken jump loads PC instead of incrementing
            // it. The register-source forms are selected with SelPC=1.
            OP_JZR, OP_JZI: begin
                if (z) begin
                    strobes.loadPC = 1'b1;
                    strobes.selPC  = (op == OP_JZR);
                end else begin
                    strobes.incPC  = 1'b1;
                end
            end
            OP_JCR, OP_JCI: begin
                if (c) begin
                    strobes.loadPC = 1'b1;
                    strobes.selPC  = (op == OP_JCR);
                end else begin
                    strobes.incPC  = 1'b1;
                end
            end
            OP_HALT: begin
                isHalt = 1'b1;
            end
            // NOP and the reserved opcodes only advance the PC.
            default: begin
                strobes.incPC = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit-opcode accumulator CPU.
// Each instruction takes FETCH (plus memory wait states), DECODE and EXEC.
// Datapath strobes are one-cycle pulses. They are decoded from the
// registered state and the registered opcode/flag latches. The only
// combinational input-to-output path is LoadIR <- mem_rdy during FETCH.
// If a fetch waits too long, the sequencer stops in FAULT. The HALT opcode
// stops it in HALT. Only CLB leaves either state.
// Parameters:
//   TIMEOUT_CYC  max FETCH cycles without mem_rdy before FAULT (>=2)
//   CNT_W        timeout counter width, 2**CNT_W >= TIMEOUT_CYC
// Ports:
//   clk, CLB (async active-low reset), run, mem_rdy, Opcode[3:0], Z, C
//   mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0],
//   SelALU[3:0], halted, fault, state_o[2:0]
module instr_cycle_sequencer
    import instr_cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       CLB,
    input  logic       run,
    input  logic       mem_rdy,
    input  logic [3:0] Opcode,
    input  logic       Z,
    input  logic       C,
    output logic       mem_req,
    output logic       LoadIR,
    output logic       IncPC,
    output logic       SelPC,
    output logic       LoadPC,
    output logic       LoadReg,
    output logic       LoadAcc,
    output logic [1:0] SelAcc,
    output logic [3:0] SelALU,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_o
);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       opLat;
    logic             zLat;
    logic             cLat;
    strobes_t         dec;
    logic             isHalt;
    logic             timeout;

    instr_cycle_sequencer_decode u_decode (
        .op      (opLat),
        .z       (zLat),
        .c       (cLat),
        .strobes (dec),
        .isHalt  (isHalt)
    );

    // cnt holds the number of FETCH cycles already spent without mem_rdy.
    // The current cycle is therefore the last allowed one when cnt reaches
    // TIMEOUT_CYC-1.
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   nextState = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (mem_rdy)      nextState = ST_DECODE;
                else if (timeout) nextState = ST_FAULT;
            end
            ST_DECODE: nextState = ST_EXEC;
            ST_EXEC: begin
                if (isHalt)   nextState = ST_HALT;
                else if (run) nextState = ST_FETCH;
                else          nextState = ST_IDLE;
            end
            ST_HALT:   nextState = ST_HALT;
            ST_FAULT:  nextState = ST_FAULT;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) state <= ST_IDLE;
        else      state <= nextState;
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            cnt <= '0;
        end else if (state == ST_FETCH && !mem_rdy) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Opcode and flags are captured in DECODE. Flag changes during EXEC
    // therefore cannot change a jump decision.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            opLat <= '0;
            zLat  <= 1'b0;
            cLat  <= 1'b0;
        end else if (state == ST_DECODE) begin
            opLat <= Opcode;
            zLat  <= Z;
            cLat  <= C;
        end
    end

    always_comb begin
        mem_req = 1'b0;
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        SelPC   = 1'b0;
        LoadPC  = 1'b0;
        LoadReg = 1'b0;
        LoadAcc = 1'b0;
        SelAcc  = '0;
        SelALU  = '0;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                LoadIR  = mem_rdy;
            end
            ST_EXEC: begin
                IncPC   = dec.incPC;
                SelPC   = dec.selPC;
                LoadPC  = dec.loadPC;
                LoadReg = dec.loadReg;
                LoadAcc = dec.loadAcc;
                SelAcc  = dec.selAcc;
                SelALU  = dec.selALU;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
module tb_instr_cycle_sequencer;

    logic       clk = 1'b0;
    logic       CLB;
    logic       run;
    logic       mem_rdy;
    logic [3:0] Opcode;
    logic       Z;
    logic       C;
    logic       mem_req;
    logic       LoadIR;
    logic       IncPC;
    logic       SelPC;
    logic       LoadPC;
    logic       LoadReg;
    logic       LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic       halted;
    logic       fault;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    instr_cycle_sequencer #(.TIMEOUT_CYC(16), .CNT_W(4)) dut (
        .clk     (clk),
        .CLB     (CLB),
        .run     (run),
        .mem_rdy (mem_rdy),
        .Opcode  (Opcode),
        .Z       (Z),
        .C       (C),
        .mem_req (mem_req),
        .LoadIR  (LoadIR),
        .IncPC   (IncPC),
        .SelPC   (SelPC),
        .LoadPC  (LoadPC),
        .LoadReg (LoadReg),
        .LoadAcc (LoadAcc),
        .SelAcc  (SelAcc),
        .SelALU  (SelALU),
        .halted  (halted),
        .fault   (fault),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // Observed outputs, packed as
    // {mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, halted, fault, state_o}
    function automatic logic [17:0] observed();
        return {mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
                SelAcc, SelALU, halted, fault, state_o};
    endfunction

    // Expected outputs outside EXEC: no datapath strobes.
    function automatic logic [17:0] quiet(input logic [2:0] st, input bit req, input bit ir,
                                          input bit h, input bit f);
        return {req, ir, 11'b0, h, f, st};
    endfunction

    // Reference model of the EXEC cycle, built from the instruction table.
    function automatic logic [17:0] expExec(input logic [3:0] op, input bit z, input bit c);
        logic [3:0] alu;
        logic [1:0] accSrc;
        bit         wrAcc, wrReg, isJump, cond, taken, regTarget, stop;
        alu = 4'b0000; accSrc = 2'b00; wrAcc = 0; wrReg = 0;
        isJump = 0; cond = 0; regTarget = 0; stop = 0;
        if (op == 4'd1) begin wrAcc = 1; alu = 4'b1000; end
        if (op == 4'd2) begin wrAcc = 1; alu = 4'b1100; end
        if (op == 4'd3) begin wrAcc = 1; alu = 4'b0100; end
        if (op == 4'd11) begin wrAcc = 1; alu = 4'b0001; end
        if (op == 4'd12) begin wrAcc = 1; alu = 4'b0011; end
        if (op == 4'd4) begin wrAcc = 1; accSrc = 2'b01; end
        if (op == 4'd5) wrReg = 1;
        if (op == 4'd13) begin wrAcc = 1; accSrc = 2'b10; end
        if (op == 4'd6 || op == 4'd7) begin isJump = 1; cond = z; regTarget = (op == 4'd6); end
        if (op == 4'd8 || op == 4'd10) begin isJump = 1; cond = c; regTarget = (op == 4'd8); end
        if (op == 4'd15) stop = 1;
        taken = isJump && cond;
        return {1'b0, 1'b0, !(taken || stop), taken && regTarget, taken, wrReg, wrAcc,
                accSrc, alu, 1'b0, 1'b0, 3'd3};
    endfunction

    task automatic doReset();
        CLB = 1'b0; run = 1'b0; mem_rdy = 1'b0; Opcode = 4'd0; Z = 1'b0; C = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 CLB = 1'b1;
    endtask

    // From IDLE (posedge+1): one IDLE cycle with run=1, then the DUT is in FETCH.
    task automatic idleToFetch(input string tag);
        logic [17:0] got, exp;
        run = 1'b1; mem_rdy = 1'($urandom);
        #1 got = observed(); exp = quiet(3'd0, 0, 0, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s idle: got=%h want=%h", tag, got, exp); end
        @(posedge clk); #1;
    endtask

    // One complete instruction, starting in FETCH at posedge+1. On return the
    // DUT is in FETCH again, or in HALT for opcode 1111.
    task automatic doInstr(input logic [3:0] op, input int waits, input bit zd, input bit cd,
                           input bit ze, input bit ce, input bit runEnd, input string tag);
        logic [17:0] got, exp;
        for (int w = 0; w < waits; w++) begin
            mem_rdy = 1'b0; run = 1'($urandom); Opcode = 4'($urandom);
            #1 got = observed(); exp = quiet(3'd1, 1, 0, 0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL %s wait%0d: got=%h want=%h", tag, w, got, exp); end
            @(posedge clk); #1;
        end
        mem_rdy = 1'b1; run = 1'($urandom); Opcode = 4'($urandom);
        #1 got = observed(); exp = quiet(3'd1, 1, 1, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s fetch: got=%h want=%h", tag, got, exp); end
        @(posedge clk); #1;
        mem_rdy = 1'($urandom); Opcode = op; Z = zd; C = cd; run = 1'($urandom);
        #1 got = observed(); exp = quiet(3'd2, 0, 0, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s decode: got=%h want=%h", tag, got, exp); end
        @(posedge clk); #1;
        mem_rdy = 1'($urandom); Opcode = 4'($urandom); Z = ze; C = ce; run = runEnd;
        #1 got = observed(); exp = expExec(op, zd, cd);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s exec op=%h: got=%h want=%h", tag, op, got, exp); end
        @(posedge clk); #1;
        if (op == 4'hF) begin
            run = 1'b1;
            #1 got = observed(); exp = quiet(3'd4, 0, 0, 1, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL %s halt entry: got=%h want=%h", tag, got, exp); end
        end else if (!runEnd) begin
            run = 1'b0;
            #1 got = observed(); exp = quiet(3'd0, 0, 0, 0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL %s idle after exec: got=%h want=%h", tag, got, exp); end
            @(posedge clk); #1;
            idleToFetch(tag);
        end
    endtask

    task automatic test_reset();
        logic [17:0] got;
        CLB = 1'b0; run = 1'b1; mem_rdy = 1'b1; Opcode = 4'd1; Z = 1'b1; C = 1'b1;
        #1 got = observed();
        total++;
        if (got !== 18'd0) begin bad++; $display("FAIL reset outputs: got=%h want=%h", got, 18'd0); end
        @(posedge clk); #1;
        got = observed();
        total++;
        if (got !== 18'd0) begin bad++; $display("FAIL reset held: got=%h want=%h", got, 18'd0); end
    endtask

    task automatic test_add_timing();
        logic [17:0] got, exp;
        doReset();
        Opcode = 4'd1;
        idleToFetch("add T0");
        doInstr(4'd1, 0, 0, 0, 0, 0, 1'b1, "add");
        mem_rdy = 1'b1;
        #1 got = observed(); exp = quiet(3'd1, 1, 1, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL add T4 fetch: got=%h want=%h", got, exp); end
    endtask

    task automatic test_jumps();
        doReset();
        idleToFetch("jump");
        doInstr(4'd7, 0, 1, 0, 0, 0, 1'b1, "jz imm taken z drops");
        doInstr(4'd7, 0, 0, 0, 1, 0, 1'b1, "jz imm not taken z rises");
        doInstr(4'd8, 0, 0, 0, 0, 1, 1'b1, "jc reg c=0");
        doInstr(4'd8, 0, 0, 1, 0, 0, 1'b1, "jc reg c=1");
        doInstr(4'd6, 0, 1, 0, 0, 1, 1'b1, "jz reg taken");
        doInstr(4'd10, 0, 1, 1, 0, 0, 1'b0, "jc imm taken");
    endtask

    task automatic test_wait_states();
        doReset();
        idleToFetch("wait");
        doInstr(4'd2, 3, 0, 0, 0, 0, 1'b1, "wait3");
        doInstr(4'd13, 15, 0, 0, 0, 0, 1'b1, "wait15");
        doInstr(4'd0, 1, 0, 0, 0, 0, 1'b1, "wait1");
    endtask

    task automatic test_random();
        doReset();
        idleToFetch("rand");
        for (int i = 0; i < 15; i++)
            doInstr(4'(i), $urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), "sweep");
        for (int i = 0; i < 250; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            doInstr(op, ($urandom % 8 == 0) ? $urandom_range(4, 15) : $urandom_range(0, 2),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom % 4) != 0, "rand");
        end
    endtask

    task automatic test_timeout();
        logic [17:0] got, exp;
        doReset();
        idleToFetch("timeout");
        for (int i = 0; i < 16; i++) begin
            mem_rdy = 1'b0; run = 1'($urandom);
            #1 got = observed(); exp = quiet(3'd1, 1, 0, 0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL timeout fetch%0d: got=%h want=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 8; i++) begin
            mem_rdy = 1'($urandom); run = 1'b1;
            #1 got = observed(); exp = quiet(3'd5, 0, 0, 0, 1);
            total++;
            if (got !== exp) begin bad++; $display("FAIL timeout fault%0d: got=%h want=%h", i, got, exp); end
            @(posedge clk); #1;
        end
        CLB = 1'b0; run = 1'b0;
        #1 got = observed();
        total++;
        if (got !== 18'd0) begin bad++; $display("FAIL fault cleared by reset: got=%h want=%h", got, 18'd0); end
        #1 CLB = 1'b1;
    endtask

    task automatic test_halt();
        logic [17:0] got, exp;
        doReset();
        idleToFetch("halt");
        doInstr(4'd1, 0, 0, 0, 0, 0, 1'b1, "pre-halt");
        doInstr(4'hF, 0, 1, 1, 0, 0, 1'b1, "halt");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            run = 1'b1; mem_rdy = 1'($urandom); Opcode = 4'($urandom);
            #1 got = observed(); exp = quiet(3'd4, 0, 0, 1, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL halt hold%0d: got=%h want=%h", i, got, exp); end
        end
    endtask

    task automatic test_reset_in_exec();
        logic [17:0] got, exp;
        doReset();
        idleToFetch("rst exec");
        mem_rdy = 1'b1; @(posedge clk); #1;
        Opcode = 4'd1; @(posedge clk); #1;
        #1 got = observed(); exp = expExec(4'd1, 0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL rst exec pre: got=%h want=%h", got, exp); end
        CLB = 1'b0;
        #1 got = observed();
        total++;
        if (got !== 18'd0) begin bad++; $display("FAIL rst exec async: got=%h want=%h", got, 18'd0); end
        @(posedge clk); #1;
        CLB = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        got = observed();
        total++;
        if (got !== 18'd0) begin bad++; $display("FAIL rst exec idle: got=%h want=%h", got, 18'd0); end
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_jumps();
        test_wait_states();
        test_random();
        test_timeout();
        test_halt();
        test_reset_in_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
